// File: rtl/spi_device_apb_requester.sv
// SPI target (mode 0, MSB first) that turns host frames into 32-bit APB reads and writes.
// Frame: command byte, 4-byte address, then data words with the address stepping by 4 per word.
module spi_device_apb_requester #(
    parameter int ADDR_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [31:0]           pwdata,
    output logic [3:0]            pstrb,
    input  logic                  pready,
    input  logic [31:0]           prdata,
    input  logic                  pslverr,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    output logic                  bus_err,
    output logic                  overrun
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_IGNORE} spi_state_e;
    typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;

    spi_state_e      spi_state_q, spi_state_d;
    apb_state_e      apb_state_q, apb_state_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [30:0]     shift_in_q, shift_in_d;
    logic            is_read_q, is_read_d;
    logic [31:0]     addr_q, addr_d;
    logic            req_pend_q, req_pend_d;
    logic            req_write_q, req_write_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [31:0]     req_wdata_q, req_wdata_d;
    logic            cur_want_q, cur_want_d;
    logic            rd_ready_q, rd_ready_d;
    logic [31:0]     rd_data_q, rd_data_d;
    logic [31:0]     miso_sh_q, miso_sh_d;
    logic            oe_q, oe_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic            pwrite_q, pwrite_d;
    logic [31:0]     pwdata_q, pwdata_d;
    logic [3:0]      pstrb_q, pstrb_d;
    logic            bus_err_q, bus_err_d;
    logic            overrun_q, overrun_d;

    logic        sck_s, cs_s, mosi_s;
    logic        sck_rise, sck_fall, cs_rise, cs_fall;
    logic [31:0] shift_word;
    logic        engine_busy;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;
    assign cs_rise     = cs_s & ~cs_prev_q;
    assign cs_fall     = ~cs_s & cs_prev_q;
    assign shift_word  = {shift_in_q, mosi_s};
    assign engine_busy = (apb_state_q != A_IDLE) || req_pend_q;

    always_comb begin
        spi_state_d = spi_state_q;
        apb_state_d = apb_state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        req_pend_d  = req_pend_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        cur_want_d  = cur_want_q;
        rd_ready_d  = rd_ready_q;
        rd_data_d   = rd_data_q;
        miso_sh_d   = miso_sh_q;
        oe_d        = oe_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        bus_err_d   = 1'b0;
        overrun_d   = 1'b0;

        case (apb_state_q)
            A_IDLE: if (req_pend_q) begin
                apb_state_d = A_SETUP;
                paddr_d     = req_addr_q[ADDR_WIDTH-1:0];
                pwrite_d    = req_write_q;
                pstrb_d     = req_write_q ? 4'hf : 4'h0;
                if (req_write_q) pwdata_d = req_wdata_q;
                cur_want_d  = ~req_write_q;
                req_pend_d  = 1'b0;
            end
            A_SETUP: apb_state_d = A_ACCESS;
            A_ACCESS: if (pready) begin
                apb_state_d = A_IDLE;
                bus_err_d   = pslverr;
                if (cur_want_q && !pwrite_q) begin
                    rd_ready_d = 1'b1;
                    rd_data_d  = pslverr ? 32'h0 : prdata;
                end
                cur_want_d  = 1'b0;
            end
            default: apb_state_d = A_IDLE;
        endcase

        // SPI side is evaluated last so frame events override engine bookkeeping
        if (cs_rise) begin
            spi_state_d = S_IDLE;
            oe_d        = 1'b0;
            cur_want_d  = 1'b0;
            rd_ready_d  = 1'b0;
            if (req_pend_q && !req_write_q) req_pend_d = 1'b0;
        end else if (cs_fall) begin
            spi_state_d = S_CMD;
            bit_cnt_d   = '0;
            shift_in_d  = '0;
        end else if (!cs_s && sck_rise && spi_state_q != S_IDLE && spi_state_q != S_IGNORE) begin
            shift_in_d = shift_word[30:0];
            bit_cnt_d  = bit_cnt_q + 6'd1;
            case (spi_state_q)
                S_CMD: if (bit_cnt_q == 6'd7) begin
                    bit_cnt_d = '0;
                    if (shift_word[7:0] == 8'h02) begin
                        spi_state_d = S_ADDR;
                        is_read_d   = 1'b0;
                    end else if (shift_word[7:0] == 8'h03) begin
                        spi_state_d = S_ADDR;
                        is_read_d   = 1'b1;
                    end else begin
                        spi_state_d = S_IGNORE;
                    end
                end
                S_ADDR: if (bit_cnt_q == 6'd31) begin
                    bit_cnt_d = '0;
                    addr_d    = shift_word;
                    if (is_read_q) begin
                        spi_state_d = S_DUMMY;
                        req_pend_d  = 1'b1;
                        req_write_d = 1'b0;
                        req_addr_d  = shift_word;
                        rd_ready_d  = 1'b0;
                    end else begin
                        spi_state_d = S_WDATA;
                    end
                end
                S_WDATA: if (bit_cnt_q == 6'd31) begin
                    bit_cnt_d = '0;
                    if (!engine_busy) begin
                        req_pend_d  = 1'b1;
                        req_write_d = 1'b1;
                        req_addr_d  = addr_q;
                        req_wdata_d = shift_word;
                    end else begin
                        overrun_d = 1'b1;
                    end
                    addr_d = addr_q + 32'd4;
                end
                default: ;
            endcase
        end else if (!cs_s && sck_fall) begin
            if ((spi_state_q == S_DUMMY && bit_cnt_q == 6'd8) ||
                (spi_state_q == S_RDATA && bit_cnt_q == 6'd32)) begin
                spi_state_d = S_RDATA;
                bit_cnt_d   = '0;
                oe_d        = 1'b1;
                if (rd_ready_q) begin
                    miso_sh_d = rd_data_q;
                end else begin
                    // late read: its result is dropped and the queued prefetch supersedes it
                    miso_sh_d  = 32'hffff_ffff;
                    overrun_d  = 1'b1;
                    cur_want_d = 1'b0;
                end
                rd_ready_d  = 1'b0;
                addr_d      = addr_q + 32'd4;
                req_pend_d  = 1'b1;
                req_write_d = 1'b0;
                req_addr_d  = addr_q + 32'd4;
            end else if (spi_state_q == S_RDATA) begin
                miso_sh_d = {miso_sh_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            spi_state_q <= S_IDLE;
            apb_state_q <= A_IDLE;
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            req_pend_q  <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            cur_want_q  <= 1'b0;
            rd_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            miso_sh_q   <= '0;
            oe_q        <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            bus_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            spi_state_q <= spi_state_d;
            apb_state_q <= apb_state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            req_pend_q  <= req_pend_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            cur_want_q  <= cur_want_d;
            rd_ready_q  <= rd_ready_d;
            rd_data_q   <= rd_data_d;
            miso_sh_q   <= miso_sh_d;
            oe_q        <= oe_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            bus_err_q   <= bus_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign psel        = (apb_state_q != A_IDLE);
    assign penable     = (apb_state_q == A_ACCESS);
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign spi_miso    = oe_q & miso_sh_q[31];
    assign spi_miso_oe = oe_q;
    assign bus_err     = bus_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_device_apb_requester.sv
// Directed bench: a host drives SPI frames, a simple APB completer logs finished transfers.
module tb_spi_device_apb_requester;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0;
    logic [31:0] prdata = 32'h0;
    logic        pslverr = 1'b0;
    logic        spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, bus_err, overrun;

    spi_device_apb_requester #(.ADDR_WIDTH(32), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .pslverr(pslverr), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .bus_err(bus_err), .overrun(overrun)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int sck_half = 5;
    int ready_delay = 0;
    int acc_cnt = 0;
    int ov_cnt = 0;
    int be_cnt = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    logic        log_write[$];
    logic [3:0]  log_strb[$];

    logic [31:0] rx, rx2;
    logic        oa, ol, ma, oe_acc, ma_acc;
    int          base_ov, base_be;

    // APB completer with programmable wait states, plus pulse counters
    always @(negedge pclk) begin
        if (psel && penable) begin
            pready = (acc_cnt >= ready_delay);
            acc_cnt++;
            if (pready) begin
                log_addr.push_back(paddr);
                log_data.push_back(pwdata);
                log_write.push_back(pwrite);
                log_strb.push_back(pstrb);
            end
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
        if (overrun) ov_cnt++;
        if (bus_err) be_cnt++;
    end

    task automatic clear_log();
        log_addr.delete(); log_data.delete(); log_write.delete(); log_strb.delete();
    endtask

    task automatic spi_bits(input logic [31:0] val, input int n, output logic [31:0] rxw,
                            output logic oe_any, output logic oe_all, output logic miso_any);
        rxw = '0; oe_any = 1'b0; oe_all = 1'b1; miso_any = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = val[i];
            repeat (sck_half) @(negedge pclk);
            rxw      = {rxw[30:0], spi_miso};
            oe_any   = oe_any | spi_miso_oe;
            oe_all   = oe_all & spi_miso_oe;
            miso_any = miso_any | spi_miso;
            spi_sck  = 1'b1;
            repeat (sck_half) @(negedge pclk);
            spi_sck  = 1'b0;
        end
    endtask

    task automatic cs_begin();
        spi_cs_n = 1'b0;
        repeat (4 * sck_half) @(negedge pclk);
    endtask

    task automatic cs_end();
        repeat (sck_half) @(negedge pclk);
        spi_cs_n = 1'b1;
        repeat (4 * sck_half) @(negedge pclk);
    endtask

    task automatic test_reset();
        preset_n = 1'b0;
        repeat (3) @(negedge pclk);
        checks++; if (psel !== 1'b0) begin errors++; $display("FAIL reset_psel: got %b want 0", psel); end
        checks++; if (penable !== 1'b0) begin errors++; $display("FAIL reset_penable: got %b want 0", penable); end
        checks++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got oe=%b miso=%b want 0/0", spi_miso_oe, spi_miso); end
        checks++; if (bus_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", bus_err, overrun); end
        checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pwrite !== 1'b0) begin errors++; $display("FAIL reset_bus: got %h %h %h %b want zeros", paddr, pwdata, pstrb, pwrite); end
        preset_n = 1'b1;
        repeat (5) @(negedge pclk);
    endtask

    task automatic test_write();
        clear_log(); base_ov = ov_cnt; base_be = be_cnt;
        cs_begin();
        spi_bits(32'h02, 8, rx, oa, ol, ma);
        spi_bits(32'hC000_0400, 32, rx, oa, ol, ma);
        spi_bits(32'h0000_00A5, 32, rx, oa, ol, ma);
        cs_end();
        repeat (20) @(negedge pclk);
        checks++; if (log_addr.size() !== 1) begin errors++; $display("FAIL write_count: got %0d want 1", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 32'hC000_0400) begin errors++; $display("FAIL write_addr: got %h want c0000400", log_addr[0]); end
            checks++; if (log_data[0] !== 32'hA5) begin errors++; $display("FAIL write_data: got %h want 000000a5", log_data[0]); end
            checks++; if (log_write[0] !== 1'b1 || log_strb[0] !== 4'hf) begin errors++; $display("FAIL write_dir_strb: got %b %h want 1 f", log_write[0], log_strb[0]); end
        end
        checks++; if (ov_cnt - base_ov !== 0 || be_cnt - base_be !== 0) begin errors++; $display("FAIL write_pulses: got ov=%0d be=%0d want 0 0", ov_cnt - base_ov, be_cnt - base_be); end
    endtask

    task automatic test_read();
        clear_log(); base_ov = ov_cnt;
        prdata = 32'h0021_0a79;
        cs_begin();
        spi_bits(32'h03, 8, rx, oa, ol, ma);         oe_acc = oa;
        spi_bits(32'hC000_0000, 32, rx, oa, ol, ma); oe_acc = oe_acc | oa;
        spi_bits(32'h0, 8, rx, oa, ol, ma);          oe_acc = oe_acc | oa;
        spi_bits(32'h0, 32, rx, oa, ol, ma);
        checks++; if (rx !== 32'h0021_0a79) begin errors++; $display("FAIL read_data: got %h want 00210a79", rx); end
        checks++; if (ol !== 1'b1) begin errors++; $display("FAIL read_oe_data: got %b want 1", ol); end
        checks++; if (oe_acc !== 1'b0) begin errors++; $display("FAIL read_oe_header: got %b want 0", oe_acc); end
        cs_end();
        checks++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin errors++; $display("FAIL read_oe_after_cs: got %b %b want 0 0", spi_miso_oe, spi_miso); end
        repeat (20) @(negedge pclk);
        checks++; if (log_addr.size() < 1) begin errors++; $display("FAIL read_count: got %0d want >=1", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 32'hC000_0000 || log_write[0] !== 1'b0 || log_strb[0] !== 4'h0) begin errors++; $display("FAIL read_apb: got %h %b %h want c0000000 0 0", log_addr[0], log_write[0], log_strb[0]); end
        end
        checks++; if (ov_cnt - base_ov !== 0) begin errors++; $display("FAIL read_overrun: got %0d want 0", ov_cnt - base_ov); end
    endtask

    task automatic test_burst_write();
        sck_half = 4; ready_delay = 0;
        clear_log();
        cs_begin();
        spi_bits(32'h02, 8, rx, oa, ol, ma);
        spi_bits(32'h0000_0400, 32, rx, oa, ol, ma);
        spi_bits(32'h1111_1111, 32, rx, oa, ol, ma);
        spi_bits(32'h2222_2222, 32, rx, oa, ol, ma);
        spi_bits(32'h3333_3333, 32, rx, oa, ol, ma);
        cs_end();
        repeat (20) @(negedge pclk);
        checks++; if (log_addr.size() !== 3) begin errors++; $display("FAIL burst_count: got %0d want 3", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 32'h400 || log_addr[1] !== 32'h404 || log_addr[2] !== 32'h408) begin errors++; $display("FAIL burst_addr: got %h %h %h want 400 404 408", log_addr[0], log_addr[1], log_addr[2]); end
            checks++; if (log_data[0] !== 32'h1111_1111 || log_data[1] !== 32'h2222_2222 || log_data[2] !== 32'h3333_3333) begin errors++; $display("FAIL burst_data: got %h %h %h", log_data[0], log_data[1], log_data[2]); end
        end
        // slow completer: the second word lands while the first write is still waiting
        ready_delay = 300;
        clear_log(); base_ov = ov_cnt;
        cs_begin();
        spi_bits(32'h02, 8, rx, oa, ol, ma);
        spi_bits(32'h0000_0400, 32, rx, oa, ol, ma);
        spi_bits(32'h1111_1111, 32, rx, oa, ol, ma);
        spi_bits(32'h2222_2222, 32, rx, oa, ol, ma);
        spi_bits(32'h3333_3333, 32, rx, oa, ol, ma);
        cs_end();
        for (int i = 0; i < 1000 && log_addr.size() < 2; i++) @(negedge pclk);
        repeat (20) @(negedge pclk);
        checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL slow_burst_count: got %0d want 2", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 32'h400 || log_addr[1] !== 32'h408) begin errors++; $display("FAIL slow_burst_addr: got %h %h want 400 408", log_addr[0], log_addr[1]); end
            checks++; if (log_data[0] !== 32'h1111_1111 || log_data[1] !== 32'h3333_3333) begin errors++; $display("FAIL slow_burst_data: got %h %h", log_data[0], log_data[1]); end
        end
        checks++; if (ov_cnt - base_ov !== 1) begin errors++; $display("FAIL slow_burst_overrun: got %0d want 1", ov_cnt - base_ov); end
        ready_delay = 0; sck_half = 5;
    endtask

    task automatic test_late_read();
        ready_delay = 300; base_ov = ov_cnt;
        cs_begin();
        spi_bits(32'h03, 8, rx, oa, ol, ma);
        spi_bits(32'h0000_0100, 32, rx, oa, ol, ma);
        spi_bits(32'h0, 8, rx, oa, ol, ma);
        spi_bits(32'h0, 8, rx, oa, ol, ma);
        checks++; if (ov_cnt - base_ov !== 1) begin errors++; $display("FAIL late_overrun: got %0d want 1", ov_cnt - base_ov); end
        spi_bits(32'h0, 24, rx2, oa, ol, ma);
        checks++; if ({rx[7:0], rx2[23:0]} !== 32'hffff_ffff) begin errors++; $display("FAIL late_data: got %h want ffffffff", {rx[7:0], rx2[23:0]}); end
        cs_end();
        repeat (1300) @(negedge pclk);
        checks++; if (psel !== 1'b0) begin errors++; $display("FAIL late_drain: got psel=%b want 0", psel); end
        ready_delay = 0; pslverr = 1'b1; prdata = 32'hdead_beef; base_be = be_cnt;
        cs_begin();
        spi_bits(32'h03, 8, rx, oa, ol, ma);
        spi_bits(32'h0000_0200, 32, rx, oa, ol, ma);
        spi_bits(32'h0, 8, rx, oa, ol, ma);
        checks++; if (be_cnt - base_be !== 1) begin errors++; $display("FAIL err_bus_err: got %0d want 1", be_cnt - base_be); end
        spi_bits(32'h0, 32, rx, oa, ol, ma);
        checks++; if (rx !== 32'h0) begin errors++; $display("FAIL err_data: got %h want 00000000", rx); end
        cs_end();
        repeat (20) @(negedge pclk);
        pslverr = 1'b0;
    endtask

    task automatic test_abort_and_wrap();
        clear_log();
        cs_begin();
        spi_bits(32'h02, 8, rx, oa, ol, ma);
        spi_bits(32'h0000_0500, 32, rx, oa, ol, ma);
        spi_bits(32'h000A_BCDE, 20, rx, oa, ol, ma);
        cs_end();
        repeat (20) @(negedge pclk);
        checks++; if (log_addr.size() !== 0) begin errors++; $display("FAIL abort_no_write: got %0d want 0", log_addr.size()); end
        cs_begin();
        spi_bits(32'h02, 8, rx, oa, ol, ma);
        spi_bits(32'hffff_fffc, 32, rx, oa, ol, ma);
        spi_bits(32'h0000_0011, 32, rx, oa, ol, ma);
        spi_bits(32'h0000_0022, 32, rx, oa, ol, ma);
        cs_end();
        repeat (20) @(negedge pclk);
        checks++; if (log_addr.size() !== 2) begin errors++; $display("FAIL wrap_count: got %0d want 2", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 32'hffff_fffc || log_addr[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", log_addr[0], log_addr[1]); end
            checks++; if (log_data[0] !== 32'h11 || log_data[1] !== 32'h22) begin errors++; $display("FAIL wrap_data: got %h %h want 11 22", log_data[0], log_data[1]); end
        end
    endtask

    task automatic test_reset_mid();
        ready_delay = 5000;
        cs_begin();
        spi_bits(32'h03, 8, rx, oa, ol, ma);
        spi_bits(32'h0000_0700, 32, rx, oa, ol, ma);
        spi_bits(32'h0, 8, rx, oa, ol, ma);
        spi_bits(32'h0, 4, rx, oa, ol, ma);
        checks++; if (ol !== 1'b1 || ma !== 1'b1) begin errors++; $display("FAIL midrst_pre_miso: got oe=%b miso=%b want 1 1", ol, ma); end
        checks++; if (psel !== 1'b1 || penable !== 1'b1) begin errors++; $display("FAIL midrst_pre_access: got %b %b want 1 1", psel, penable); end
        preset_n = 1'b0;
        #1;
        checks++; if (psel !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL midrst_apb: got %b %b want 0 0", psel, penable); end
        checks++; if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b %b want 0 0", spi_miso_oe, spi_miso); end
        repeat (3) @(negedge pclk);
        spi_cs_n = 1'b1; ready_delay = 0;
        repeat (3) @(negedge pclk);
        preset_n = 1'b1;
        repeat (10) @(negedge pclk);
        clear_log();
        cs_begin();
        spi_bits(32'h9F, 8, rx, oa, ol, ma);         oe_acc = oa; ma_acc = ma;
        spi_bits(32'hffff_ffff, 32, rx, oa, ol, ma); oe_acc = oe_acc | oa; ma_acc = ma_acc | ma;
        cs_end();
        repeat (20) @(negedge pclk);
        checks++; if (log_addr.size() !== 0 || psel !== 1'b0) begin errors++; $display("FAIL ignore_apb: got %0d transfers psel=%b want 0 0", log_addr.size(), psel); end
        checks++; if (ma_acc !== 1'b0 || oe_acc !== 1'b0) begin errors++; $display("FAIL ignore_miso: got miso=%b oe=%b want 0 0", ma_acc, oe_acc); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst_write();
        test_late_read();
        test_abort_and_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_device_apb_requester.md
Name: spi_device_apb_requester

Overview:
- SPI device (target) endpoint that lets an external SPI host, such as a debug MCU, issue 32-bit reads and writes onto an on-chip APB segment.
- Acts as the APB requester feeding the peripheral bridge; all SPI inputs are oversampled in the pclk domain.
- Wire protocol: mode 0, MSB first; command byte, 4-byte address, then data.
- Address auto-increments by 4 per data word (burst).

Parameters:
- ADDR_WIDTH, 32, width of paddr; driven from the low bits of the 32-bit wire address.
- SYNC_STAGES, 2, synchronizer depth on spi_sck, spi_cs_n and spi_mosi (minimum 2).

Ports:
- pclk  input  1  APB clock; only clock in block
- preset_n  input  1  asynchronous active-low reset
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  32  APB write data
- pstrb  output  4  byte strobes; always 4'hf on writes, 4'h0 on reads
- pready  input  1  completer ready
- prdata  input  32  completer read data
- pslverr  input  1  completer error
- spi_sck  input  1  host clock; pclk >= 6x sck frequency
- spi_cs_n  input  1  host chip select
- spi_mosi  input  1  host data in
- spi_miso  output  1  data out
- spi_miso_oe  output  1  tristate enable for spi_miso; high only while cs asserted in a read data phase
- bus_err  output  1  one-cycle pulse when a transaction completes with pslverr
- overrun  output  1  one-cycle pulse on a dropped write or a late read

Behaviour:
- Reset (preset_n low): all outputs 0; state IDLE; shift registers cleared. Asserting reset mid-frame or mid-APB drops everything immediately. APB protocol violation by reset is accepted.
- Sync: sck, cs_n and mosi each pass through SYNC_STAGES flops. Edges are detected on the synchronized sck.
- mosi is sampled on the detected rising edge; miso is updated on the detected falling edge.
- Frame start: synchronized cs_n falling edge. This resets the bit counter and enters CMD.
- Bits are only counted while cs_n is low.
- SPI states:
  - CMD: 8 bits. 0x02 goes to ADDR (write). 0x03 goes to ADDR (read). Any other value goes to IGNORE until cs_n rises.
  - ADDR: 32 bits. On completion, latch addr. Write goes to WDATA; read goes to DUMMY and launches APB read at addr.
  - WDATA: each 32 bits forms a word.
    - If the APB engine is idle: launch write(addr, word), then addr += 4.
    - If busy: drop the word, pulse overrun, addr += 4.
    - Continue in WDATA.
  - DUMMY: 8 bits. At the falling edge after the last dummy bit, load the miso shift register and go to RDATA.
  - RDATA: shift out 32 bits. At the word boundary, launch the next read at addr+4 (prefetch) and shift the next word out after 8 further bits?
    - Decided instead: no extra dummy between burst words. The prefetch is launched at bit 0 of the current word, and its result loads at the word boundary.
- Read load value:
  - prdata captured at APB completion, or 32'h0 if pslverr was set.
  - If APB is still pending at load time: load 32'hffff_ffff and pulse overrun. The late result is discarded when it completes.
- spi_miso_oe: 1 from the first load in RDATA until cs_n rises; otherwise spi_miso = 0.
- cs_n rising mid-frame:
  - Return to IDLE; a partial write word is discarded.
  - An in-flight APB transfer always completes per protocol; its read data is discarded and bus_err still pulses on error.
  - cs_n falling again while the APB engine is still busy is accepted. A launch waits for the engine to go idle, which holds the write-drop and late-read rules above.
- APB engine:
  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata stable.
  - ACCESS: penable=1, held until pready.
  - On pready: psel=0, penable=0 in the next cycle. Back-to-back transfers need at least one idle cycle.
  - pwdata is held at its last value when idle.
- bus_err pulses in the cycle after pready with pslverr=1.
- Address arithmetic: 32-bit wrap (0xffff_fffc + 4 = 0x0000_0000); paddr = addr[ADDR_WIDTH-1:0].

Test Plan:
- Write 0x02, 0xC0000400, 0x000000A5 with pready tied high -> one APB write: paddr=0xC0000400, pwdata=0xA5, pstrb=0xf. No bus_err, no overrun.
- Read 0x03, 0xC0000000, dummy, 32 clocks with prdata=0x00210a79 -> miso shifts 0x00210a79 MSB first. spi_miso_oe is 1 only during the data bits.
- Burst write of 3 words at 0x400 -> writes at 0x400, 0x404, 0x408. With pready delayed 300 pclk, word 2 is dropped and overrun pulses once.
- Read with pready delayed beyond the dummy byte -> 0xffffffff shifted and overrun pulses. With pslverr=1 and a prompt pready -> 0x00000000 shifted and bus_err pulses.
- Deassert cs_n after 20 write-data bits -> no APB write. Next frame 0x02 at 0xfffffffc for two words -> writes at 0xfffffffc then 0x00000000.
- Pull preset_n low mid-ACCESS -> psel, penable, spi_miso_oe and spi_miso are all 0 immediately. Command 0x9F -> no APB activity, miso stays low.
